// File: rtl/eth_hdr_rx_parse_pkg.sv
// ---------------------------------------------------------------------------
// eth_hdr_rx_parse_pkg : Ethernet header offsets, parser states, helpers. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package eth_hdr_rx_parse_pkg;

  localparam logic [3:0] ETH_DEST_OFFSET = 4'd0;
  localparam logic [3:0] ETH_SRC_OFFSET  = 4'd6;
  localparam logic [3:0] ETH_TYPE_OFFSET = 4'd12;
  localparam logic [3:0] ETH_HDR_LEN     = 4'd14;
  localparam logic [3:0] ETH_HDR_LAST    = ETH_HDR_LEN - 4'd1;

  typedef logic [1:0] state_t;
  localparam state_t ST_HDR     = 2'd0;
  localparam state_t ST_PAYLOAD = 2'd1;
  localparam state_t ST_DROP    = 2'd2;

  // Header bytes 0..12; byte 13 is taken straight from the input stream.
  typedef logic [7:0] hdr_buf_t [0:ETH_HDR_LEN-4'd2];

  function automatic logic [47:0] pack_mac(input hdr_buf_t b, input logic [3:0] off);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r = {r[39:0], b[off + 4'(i)]};
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/eth_hdr_rx_parse.sv
// ---------------------------------------------------------------------------
// eth_hdr_rx_parse : 8-bit Ethernet receive header parser / payload splitter. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module eth_hdr_rx_parse
  import eth_hdr_rx_parse_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        m_eth_hdr_valid,
  input  logic        m_eth_hdr_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,
  output logic [7:0]  m_eth_payload_axis_tdata,
  output logic        m_eth_payload_axis_tvalid,
  input  logic        m_eth_payload_axis_tready,
  output logic        m_eth_payload_axis_tlast,
  output logic        m_eth_payload_axis_tuser,
  output logic        busy,
  output logic        error_header_early_termination,
  output logic        error_overflow
);

  state_t     state, state_next;
  logic [3:0] hdr_cnt;
  hdr_buf_t   hdr_buf;

  logic hdr_early, hdr_done, hdr_accept, hdr_overflow;
  logic pay_stall, pay_load, pay_overflow;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HDR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_HDR:
        if (hdr_done) state_next = m_eth_hdr_valid ? ST_DROP : ST_PAYLOAD;
      ST_PAYLOAD:
        if (s_axis_tvalid) begin
          if (s_axis_tlast)   state_next = ST_HDR;
          else if (pay_stall) state_next = ST_DROP;
        end
      ST_DROP:
        if (s_axis_tvalid && s_axis_tlast) state_next = ST_HDR;
      default: state_next = ST_HDR;
    endcase
  end

  always_comb begin
    busy         = (state != ST_HDR);
    pay_stall    = m_eth_payload_axis_tvalid && !m_eth_payload_axis_tready;
    hdr_early    = (state == ST_HDR) && s_axis_tvalid && s_axis_tlast;
    hdr_done     = (state == ST_HDR) && s_axis_tvalid && !s_axis_tlast && (hdr_cnt == ETH_HDR_LAST);
    hdr_accept   = hdr_done && !m_eth_hdr_valid;
    hdr_overflow = hdr_done && m_eth_hdr_valid;
    pay_load     = (state == ST_PAYLOAD) && s_axis_tvalid && !pay_stall;
    pay_overflow = (state == ST_PAYLOAD) && s_axis_tvalid && pay_stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_cnt                        <= 4'd0;
      m_eth_hdr_valid                <= 1'b0;
      error_header_early_termination <= 1'b0;
      error_overflow                 <= 1'b0;
    end else begin
      error_header_early_termination <= hdr_early;
      error_overflow                 <= hdr_overflow || pay_overflow;
      if (m_eth_hdr_valid && m_eth_hdr_ready) m_eth_hdr_valid <= 1'b0;
      if (hdr_accept)                         m_eth_hdr_valid <= 1'b1;
      if (state == ST_HDR && s_axis_tvalid)
        hdr_cnt <= (s_axis_tlast || hdr_cnt == ETH_HDR_LAST) ? 4'd0 : hdr_cnt + 4'd1;
    end
  end

  // Collection buffer is separate from the output fields so they stay stable while valid.
  always_ff @(posedge clk) begin
    if (state == ST_HDR && s_axis_tvalid && hdr_cnt != ETH_HDR_LAST)
      hdr_buf[hdr_cnt] <= s_axis_tdata;
    if (hdr_accept) begin
      m_eth_dest_mac <= pack_mac(hdr_buf, ETH_DEST_OFFSET);
      m_eth_src_mac  <= pack_mac(hdr_buf, ETH_SRC_OFFSET);
      m_eth_type     <= {hdr_buf[ETH_TYPE_OFFSET], s_axis_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             m_eth_payload_axis_tvalid <= 1'b0;
    else if (pay_load)   m_eth_payload_axis_tvalid <= 1'b1;
    else if (!pay_stall) m_eth_payload_axis_tvalid <= 1'b0;
  end

  // On overflow the held byte becomes a truncated, errored end of frame.
  always_ff @(posedge clk) begin
    if (pay_load) begin
      m_eth_payload_axis_tdata <= s_axis_tdata;
      m_eth_payload_axis_tlast <= s_axis_tlast;
      m_eth_payload_axis_tuser <= s_axis_tlast && s_axis_tuser;
    end else if (pay_overflow) begin
      m_eth_payload_axis_tlast <= 1'b1;
      m_eth_payload_axis_tuser <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eth_hdr_rx_parse.sv
// ---------------------------------------------------------------------------
// tb_eth_hdr_rx_parse : scoreboard bench for eth_hdr_rx_parse. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_eth_hdr_rx_parse;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tuser;
  logic        hdr_valid, hdr_ready;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] eth_type;
  logic [7:0]  p_tdata;
  logic        p_tvalid, p_tready, p_tlast, p_tuser;
  logic        busy, err_early, err_ovf;

  eth_hdr_rx_parse dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_eth_hdr_valid(hdr_valid), .m_eth_hdr_ready(hdr_ready),
    .m_eth_dest_mac(dest_mac), .m_eth_src_mac(src_mac), .m_eth_type(eth_type),
    .m_eth_payload_axis_tdata(p_tdata), .m_eth_payload_axis_tvalid(p_tvalid),
    .m_eth_payload_axis_tready(p_tready), .m_eth_payload_axis_tlast(p_tlast),
    .m_eth_payload_axis_tuser(p_tuser),
    .busy(busy),
    .error_header_early_termination(err_early), .error_overflow(err_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [47:0] dst; logic [47:0] src; logic [15:0] typ; int cyc; } hdr_t;
  typedef struct { logic [7:0] data; logic last; logic user; int cyc; } pay_t;

  hdr_t       hdr_q[$];
  pay_t       pay_q[$];
  logic [7:0] evt_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: DUT produced output with nothing expected (cycle %0d)", nm, cyc);
  endtask

  // Frame-level reference: what a frame should produce given whether the header
  // slot is occupied, which payload index sees a stalled output, and where an abort cuts it.
  task automatic model_frame(input logic [7:0] f[$], input logic user, input int stall_k,
                             input bit hdr_full, input int cyc0, input bit hdr_chk, input int abort_j);
    hdr_t h;
    int   len, npay;
    len  = (abort_j >= 0) ? abort_j : f.size();
    npay = len - 14;
    if (abort_j < 0 && f.size() <= 14) begin evt_q.push_back("E"); return; end
    if (npay < 0) return;
    if (hdr_full) begin evt_q.push_back("O"); return; end
    h.dst = '0; h.src = '0;
    for (int i = 0; i < 6; i++) begin
      h.dst = {h.dst[39:0], f[i]};
      h.src = {h.src[39:0], f[6+i]};
    end
    h.typ = {f[12], f[13]};
    h.cyc = hdr_chk ? cyc0 + 14 : -1;
    hdr_q.push_back(h);
    for (int p = 0; p < npay; p++) begin
      pay_t e;
      e.data = f[14+p];
      e.cyc  = cyc0 + 15 + p;
      if (stall_k >= 0 && p == stall_k) begin
        e.last = 1'b1; e.user = 1'b1; e.cyc = -1;
        pay_q.push_back(e);
        evt_q.push_back("O");
        return;
      end
      e.last = (abort_j < 0) && (p == npay - 1);
      e.user = e.last && user;
      pay_q.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input logic user, input int stall_k,
                            input bit hdr_full, input bit hdr_chk, input int abort_j);
    model_frame(f, user, stall_k, hdr_full, cyc, hdr_chk, abort_j);
    for (int j = 0; j < f.size(); j++) begin
      if (abort_j >= 0 && j == abort_j) break;
      s_tvalid = 1'b1;
      s_tdata  = f[j];
      s_tlast  = (j == f.size() - 1);
      s_tuser  = s_tlast ? user : 1'($urandom);
      if (stall_k >= 0 && j == 14 + stall_k + 1) p_tready = 1'b0;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rand_frame(output logic [7:0] f[$], input int len);
    f = {};
    for (int i = 0; i < len; i++) f.push_back(8'($urandom));
  endtask

  task automatic std_frame(output logic [7:0] f[$]);
    rand_frame(f, 64);
    for (int i = 0; i < 6; i++) f[i] = 8'hFF;
    f[6] = 8'h02; f[7] = 8'h00; f[8] = 8'h00; f[9] = 8'h00; f[10] = 8'h00; f[11] = 8'h01;
    f[12] = 8'h08; f[13] = 8'h00;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_hdr_valid"}, 64'(hdr_valid), 64'd0);
    chk({tag, "_pay_tvalid"}, 64'(p_tvalid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err_early"}, 64'(err_early), 64'd0);
    chk({tag, "_err_ovf"}, 64'(err_ovf), 64'd0);
  endtask

  // Monitor: pops expectations whenever the DUT presents something.
  always @(negedge clk) begin
    if (hdr_valid === 1'b1 && hdr_ready === 1'b1) begin
      if (hdr_q.size() == 0) unexpected("hdr");
      else begin
        hdr_t h;
        h = hdr_q.pop_front();
        chk("hdr_dest", 64'(dest_mac), 64'(h.dst));
        chk("hdr_src", 64'(src_mac), 64'(h.src));
        chk("hdr_type", 64'(eth_type), 64'(h.typ));
        if (h.cyc >= 0) chk("hdr_latency", 64'(cyc), 64'(h.cyc));
      end
    end
    if (p_tvalid === 1'b1 && p_tready === 1'b1) begin
      if (pay_q.size() == 0) unexpected("payload");
      else begin
        pay_t e;
        e = pay_q.pop_front();
        chk("pay_data", 64'(p_tdata), 64'(e.data));
        chk("pay_last", 64'(p_tlast), 64'(e.last));
        chk("pay_user", 64'(p_tuser), 64'(e.user));
        if (e.cyc >= 0) chk("pay_latency", 64'(cyc), 64'(e.cyc));
      end
    end
    if (err_early === 1'b1) begin
      if (evt_q.size() == 0) unexpected("err_early");
      else chk("err_early_evt", 64'(8'h45), 64'(evt_q.pop_front()));
    end
    if (err_ovf === 1'b1) begin
      if (evt_q.size() == 0) unexpected("err_overflow");
      else chk("err_overflow_evt", 64'(8'h4F), 64'(evt_q.pop_front()));
    end
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] g[$];
    rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    hdr_ready = 1'b1; p_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;
    idle(1);

    // Standard 64-byte frame
    std_frame(f);
    send_frame(f, 1'b0, -1, 1'b0, 1'b1, -1);
    idle(3);

    // Short frame terminates early; next frame still parses
    rand_frame(f, 10);
    send_frame(f, 1'b0, -1, 1'b0, 1'b1, -1);
    idle(2);
    std_frame(f);
    send_frame(f, 1'b0, -1, 1'b0, 1'b1, -1);
    idle(3);

    // Bad-frame flag on a good frame passes through to the last payload byte
    rand_frame(f, 30);
    send_frame(f, 1'b1, -1, 1'b0, 1'b1, -1);
    idle(3);

    // Header slot still full when the next header completes
    hdr_ready = 1'b0;
    std_frame(f);
    send_frame(f, 1'b0, -1, 1'b0, 1'b0, -1);
    rand_frame(g, 64);
    send_frame(g, 1'b0, -1, 1'b1, 1'b0, -1);
    idle(4);
    hdr_ready = 1'b1;
    idle(3);

    // Payload stall at byte 5: held byte becomes errored end of frame
    std_frame(f);
    send_frame(f, 1'b0, 5, 1'b0, 1'b1, -1);
    chk("busy_after_drop", 64'(busy), 64'd0);
    idle(4);
    p_tready = 1'b1;
    idle(3);

    // Reset in the middle of the payload; remainder is parsed as a new frame
    std_frame(f);
    send_frame(f, 1'b0, -1, 1'b0, 1'b1, 34);
    chk("busy_mid_payload", 64'(busy), 64'd1);
    rst = 1'b1;
    idle(1);
    chk_reset_state("midreset");
    rst = 1'b0;
    g = f[34:63];
    send_frame(g, 1'b1, -1, 1'b0, 1'b1, -1);
    idle(3);

    // Randomized frames, including boundary lengths, with random gaps
    for (int n = 0; n < 40; n++) begin
      int len;
      if (n == 0)      len = 13;
      else if (n == 1) len = 14;
      else if (n == 2) len = 15;
      else             len = $urandom_range(1, 48);
      rand_frame(f, len);
      send_frame(f, 1'($urandom), -1, 1'b0, 1'b1, -1);
      idle($urandom_range(0, 3));
    end

    for (int t = 0; t < 300 && (hdr_q.size() + pay_q.size() + evt_q.size()) != 0; t++) idle(1);
    chk("hdr_q_drained", 64'(hdr_q.size()), 64'd0);
    chk("pay_q_drained", 64'(pay_q.size()), 64'd0);
    chk("evt_q_drained", 64'(evt_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
